// File: rtl/hvac_sequencer.sv
// hvac_sequencer
//   Sequences a single-stage heat/cool plant with fan pre-purge, a minimum
//   run time, fan post-purge and an equipment-off lockout.
//
// Ports
//   clk               : system clock, all state updates on the rising edge
//   reset             : asynchronous, active-high reset
//   user_temp_setting : 8-bit unsigned setpoint
//   indoor_temp       : 8-bit unsigned measured temperature
//   heating           : heat equipment enable
//   cooling           : cool equipment enable
//   fan_en            : air-handler fan enable
//   busy              : high whenever the sequencer is not IDLE
//   state             : current state (IDLE=0, PRE=1, HEAT=2, COOL=3, POST=4, LOCK=5)

module hvac_sequencer #(
  parameter int unsigned HYST     = 2,
  parameter int unsigned PRE_CYC  = 4,
  parameter int unsigned MIN_RUN  = 8,
  parameter int unsigned POST_CYC = 4,
  parameter int unsigned LOCK_CYC = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] user_temp_setting,
  input  logic [7:0] indoor_temp,
  output logic       heating,
  output logic       cooling,
  output logic       fan_en,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_HEAT = 3'd2;
  localparam logic [2:0] ST_COOL = 3'd3;
  localparam logic [2:0] ST_POST = 3'd4;
  localparam logic [2:0] ST_LOCK = 3'd5;

  localparam logic MODE_HEAT = 1'b0;
  localparam logic MODE_COOL = 1'b1;

  // Counter reload values: each timed state lasts exactly N cycles because
  // the counter is loaded with N-1 on entry and the state exits at zero.
  localparam logic [7:0] PRE_LOAD  = 8'(PRE_CYC - 1);
  localparam logic [7:0] RUN_LOAD  = 8'(MIN_RUN - 1);
  localparam logic [7:0] POST_LOAD = 8'(POST_CYC - 1);
  localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYC - 1);

  localparam logic [8:0] HYST9 = 9'(HYST);

  logic [2:0] state_q;
  logic [7:0] count_q;
  logic       mode_q;

  logic [8:0] set9;
  logic [8:0] temp9;
  logic       heat_dmd;
  logic       cool_dmd;
  logic       mode_dmd;
  logic       heat_satisfied;
  logic       cool_satisfied;

  // Demand is evaluated one bit wider than the inputs so that adding the
  // deadband to a near-full-scale reading can never wrap around.
  assign set9     = {1'b0, user_temp_setting};
  assign temp9    = {1'b0, indoor_temp};
  assign heat_dmd = (temp9 + HYST9) < set9;
  assign cool_dmd = temp9 > (set9 + HYST9);

  // Demand for the mode latched on leaving IDLE; used to abort pre-purge.
  assign mode_dmd = (mode_q == MODE_COOL) ? cool_dmd : heat_dmd;

  // Run-state exit thresholds are the setpoint itself, not the deadband
  // edge, so a run always drives the room fully back to the setpoint.
  assign heat_satisfied = indoor_temp >= user_temp_setting;
  assign cool_satisfied = indoor_temp <= user_temp_setting;

  // Sequencer state, shared down-counter and latched heat/cool mode.
  // In HEAT/COOL the counter parks at zero once the minimum run time has
  // elapsed, so the run continues until the temperature exit is met.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= 8'd0;
      mode_q  <= MODE_HEAT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (heat_dmd) begin
            state_q <= ST_PRE;
            mode_q  <= MODE_HEAT;
            count_q <= PRE_LOAD;
          end else if (cool_dmd) begin
            state_q <= ST_PRE;
            mode_q  <= MODE_COOL;
            count_q <= PRE_LOAD;
          end
        end
        ST_PRE: begin
          if (!mode_dmd) begin
            state_q <= ST_IDLE;
            count_q <= 8'd0;
          end else if (count_q == 8'd0) begin
            state_q <= (mode_q == MODE_COOL) ? ST_COOL : ST_HEAT;
            count_q <= RUN_LOAD;
          end else begin
            count_q <= count_q - 8'd1;
          end
        end
        ST_HEAT: begin
          if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
          end else if (heat_satisfied) begin
            state_q <= ST_POST;
            count_q <= POST_LOAD;
          end
        end
        ST_COOL: begin
          if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
          end else if (cool_satisfied) begin
            state_q <= ST_POST;
            count_q <= POST_LOAD;
          end
        end
        ST_POST: begin
          if (count_q == 8'd0) begin
            state_q <= ST_LOCK;
            count_q <= LOCK_LOAD;
          end else begin
            count_q <= count_q - 8'd1;
          end
        end
        ST_LOCK: begin
          if (count_q == 8'd0) begin
            state_q <= ST_IDLE;
          end else begin
            count_q <= count_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= 8'd0;
        end
      endcase
    end
  end

  // Moore output decode; because reset clears state_q asynchronously the
  // enables drop the moment reset rises, without waiting for a clock.
  assign heating = (state_q == ST_HEAT);
  assign cooling = (state_q == ST_COOL);
  assign fan_en  = (state_q == ST_PRE) || (state_q == ST_HEAT) ||
                   (state_q == ST_COOL) || (state_q == ST_POST);
  assign busy    = (state_q != ST_IDLE);
  assign state   = state_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// tb_hvac_sequencer
//   Self-checking bench for hvac_sequencer. A behavioural model tracks the
//   current phase and how many cycles have been spent in it, and derives the
//   expected enables from the phase.

module tb_hvac_sequencer;

  localparam int HYST     = 2;
  localparam int PRE_CYC  = 4;
  localparam int MIN_RUN  = 8;
  localparam int POST_CYC = 4;
  localparam int LOCK_CYC = 6;

  localparam int S_IDLE = 0;
  localparam int S_PRE  = 1;
  localparam int S_HEAT = 2;
  localparam int S_COOL = 3;
  localparam int S_POST = 4;
  localparam int S_LOCK = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] set_t = 8'h00;
  logic [7:0] in_t = 8'h00;
  logic       heating;
  logic       cooling;
  logic       fan_en;
  logic       busy;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase, cycles spent in it, and whether the run is cooling
  int m_state = S_IDLE;
  int m_elapsed = 0;
  bit m_cool = 1'b0;

  hvac_sequencer #(
    .HYST(HYST), .PRE_CYC(PRE_CYC), .MIN_RUN(MIN_RUN),
    .POST_CYC(POST_CYC), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .user_temp_setting(set_t),
    .indoor_temp(in_t),
    .heating(heating),
    .cooling(cooling),
    .fan_en(fan_en),
    .busy(busy),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state   = S_IDLE;
    m_elapsed = 0;
    m_cool    = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge
  task automatic model_edge();
    int s;
    int t;
    bit hd;
    bit cd;
    s  = int'(set_t);
    t  = int'(in_t);
    hd = (t + HYST) < s;
    cd = t > (s + HYST);
    case (m_state)
      S_IDLE: begin
        if (hd) begin
          m_state = S_PRE; m_cool = 1'b0; m_elapsed = 1;
        end else if (cd) begin
          m_state = S_PRE; m_cool = 1'b1; m_elapsed = 1;
        end
      end
      S_PRE: begin
        if (m_cool ? !cd : !hd) begin
          m_state = S_IDLE; m_elapsed = 0;
        end else if (m_elapsed >= PRE_CYC) begin
          m_state = m_cool ? S_COOL : S_HEAT; m_elapsed = 1;
        end else m_elapsed++;
      end
      S_HEAT: begin
        if (m_elapsed >= MIN_RUN && t >= s) begin
          m_state = S_POST; m_elapsed = 1;
        end else m_elapsed++;
      end
      S_COOL: begin
        if (m_elapsed >= MIN_RUN && t <= s) begin
          m_state = S_POST; m_elapsed = 1;
        end else m_elapsed++;
      end
      S_POST: begin
        if (m_elapsed >= POST_CYC) begin
          m_state = S_LOCK; m_elapsed = 1;
        end else m_elapsed++;
      end
      S_LOCK: begin
        if (m_elapsed >= LOCK_CYC) begin
          m_state = S_IDLE; m_elapsed = 0;
        end else m_elapsed++;
      end
      default: m_state = S_IDLE;
    endcase
  endtask

  function automatic logic [6:0] exp_vec();
    logic h;
    logic c;
    logic f;
    logic b;
    h = (m_state == S_HEAT);
    c = (m_state == S_COOL);
    f = (m_state == S_PRE) || (m_state == S_HEAT) || (m_state == S_COOL) || (m_state == S_POST);
    b = (m_state != S_IDLE);
    return {3'(m_state), h, c, f, b};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {state, heating, cooling, fan_en, busy};
  endfunction

  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] t);
    set_t = s;
    in_t  = t;
  endtask

  // One rising edge; returns 1 time unit later so outputs are stable
  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int pre_seen;
    reset = 1'b0;
    applyStimulus(8'h20, 8'h28);
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: got %b expected %b", dut_vec(), 7'b0);
    end
    tick();
    tick();
    checks++;
    if (dut_vec() !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_held: got %b expected %b", dut_vec(), 7'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    pre_seen = 0;
    for (int i = 0; i < PRE_CYC; i++) begin
      tick();
      checks++;
      if (dut_vec() !== {3'd1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
        errors++;
        $display("[TB] FAIL reset_pre cycle %0d: got %b expected %b", i, dut_vec(), {3'd1, 4'b0011});
      end
      if (state === 3'd1) pre_seen++;
    end
    checks++;
    if (pre_seen !== PRE_CYC) begin
      errors++;
      $display("[TB] FAIL reset_pre_len: got %0d expected %0d", pre_seen, PRE_CYC);
    end
    tick();
    checks++;
    if (cooling !== 1'b1 || heating !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_cool_entry: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  // Starts in the first COOL cycle left by test_reset
  task automatic test_cool_cycle();
    int cool_n;
    int post_n;
    int lock_n;
    bit done;
    cool_n = cooling ? 1 : 0;
    post_n = 0;
    lock_n = 0;
    done   = 1'b0;
    tick();
    if (cooling === 1'b1) cool_n++;
    applyStimulus(8'h20, 8'h20);
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL cool_seq cycle %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (cooling === 1'b1) cool_n++;
      if (state === 3'd4 && fan_en === 1'b1 && cooling === 1'b0) post_n++;
      if (state === 3'd5 && fan_en === 1'b0) lock_n++;
      if (state === 3'd0 && m_state == S_IDLE) done = 1'b1;
    end
    checks++;
    if (!done || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cool_idle: done=%0d busy=%b expected done=1 busy=0", done, busy);
    end
    checks++;
    if (cool_n != MIN_RUN) begin
      errors++;
      $display("[TB] FAIL cool_len: got %0d expected %0d", cool_n, MIN_RUN);
    end
    checks++;
    if (post_n != POST_CYC) begin
      errors++;
      $display("[TB] FAIL post_len: got %0d expected %0d", post_n, POST_CYC);
    end
    checks++;
    if (lock_n != LOCK_CYC) begin
      errors++;
      $display("[TB] FAIL lock_len: got %0d expected %0d", lock_n, LOCK_CYC);
    end
  endtask

  task automatic test_deadband();
    applyStimulus(8'h20, 8'h22);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_vec() !== 7'b0) begin
        errors++;
        $display("[TB] FAIL deadband_idle cycle %0d: got %b expected %b", i, dut_vec(), 7'b0);
      end
    end
    applyStimulus(8'h20, 8'h23);
    tick();
    checks++;
    if (state !== 3'd1 || fan_en !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL deadband_start: got %b expected %b", dut_vec(), exp_vec());
    end
    // Demand drops during pre-purge: straight back to IDLE, no lockout
    applyStimulus(8'h20, 8'h20);
    tick();
    checks++;
    if (dut_vec() !== 7'b0 || m_state != S_IDLE) begin
      errors++;
      $display("[TB] FAIL pre_abort: got %b expected %b", dut_vec(), 7'b0);
    end
    tick();
    checks++;
    if (dut_vec() !== 7'b0) begin
      errors++;
      $display("[TB] FAIL pre_abort_stay: got %b expected %b", dut_vec(), 7'b0);
    end
  endtask

  task automatic test_lock_hold();
    int exp_seq[$];
    applyStimulus(8'h18, 8'h10);
    for (int i = 0; i < 20 && m_state != S_POST; i++) begin
      if (m_state == S_HEAT && m_elapsed == 3) applyStimulus(8'h18, 8'h18);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL lock_run cycle %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    applyStimulus(8'h18, 8'h10);
    for (int i = 1; i < POST_CYC; i++) exp_seq.push_back(S_POST);
    for (int i = 0; i < LOCK_CYC; i++) exp_seq.push_back(S_LOCK);
    exp_seq.push_back(S_IDLE);
    for (int i = 0; i < PRE_CYC; i++) exp_seq.push_back(S_PRE);
    exp_seq.push_back(S_HEAT);
    foreach (exp_seq[i]) begin
      tick();
      checks++;
      if (state !== 3'(exp_seq[i]) || dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL lock_seq step %0d: got state %0d vec %b expected state %0d vec %b",
                 i, state, dut_vec(), exp_seq[i], exp_vec());
      end
    end
    checks++;
    if (heating !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_reheat: got heating=%b expected 1", heating);
    end
  endtask

  task automatic test_no_wrap();
    pulse_reset();
    applyStimulus(8'hFF, 8'h00);
    for (int i = 0; i <= PRE_CYC; i++) tick();
    checks++;
    if (state !== 3'd2 || heating !== 1'b1 || cooling !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_heat: got state %0d heating %b expected state 2 heating 1", state, heating);
    end
    pulse_reset();
    applyStimulus(8'h00, 8'hFF);
    for (int i = 0; i <= PRE_CYC; i++) tick();
    checks++;
    if (state !== 3'd3 || cooling !== 1'b1 || heating !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_cool: got state %0d cooling %b expected state 3 cooling 1", state, cooling);
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    applyStimulus(8'h30, 8'h10);
    for (int i = 0; i < 20 && m_state != S_HEAT; i++) tick();
    tick();
    tick();
    checks++;
    if (heating !== 1'b1 || fan_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_pre_heat: got heating %b fan %b expected 1 1", heating, fan_en);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (heating !== 1'b0 || fan_en !== 1'b0 || state !== 3'd0 || clk !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_drop: got heating %b fan %b state %0d expected 0 0 0", heating, fan_en, state);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if (state !== 3'd1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL async_restart: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int hold;
    int base;
    int t;
    hold = 0;
    pulse_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 19) == 0) begin
          base = int'($urandom_range(0, 255));
          t    = int'($urandom_range(0, 255));
        end else begin
          base = int'($urandom_range(16, 48));
          t    = base + int'($urandom_range(0, 12)) - 6;
        end
        applyStimulus(8'(base), 8'(t));
        hold = int'($urandom_range(1, 12));
      end else hold--;
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || (heating === 1'b1 && cooling === 1'b1)) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", cyc, dut_vec(), exp_vec());
      end
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 7'b0) begin
          errors++;
          $display("[TB] FAIL random_reset cycle %0d: got %b expected %b", cyc, dut_vec(), 7'b0);
        end
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    $display("[TB] hvac_sequencer bench starting");
    test_reset();
    test_cool_cycle();
    test_deadband();
    test_lock_hold();
    test_no_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
